serial_tx_scheduler: RTL and testbench

Byte-level transmit scheduler that feeds the lane parallel-to-serial converter. Each cycle the converter shifts one bit, so the scheduler presents one stable byte every WIDTH cycles. At each byte boundary it picks the next byte from up to NREQ requesters using round-robin arbitration. It also emits alignment and idle symbols and drives the converter's enable. It sits between the transmit byte FIFOs and the serializer on each lane.

---
 rtl/serial_tx_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_serial_tx_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler: byte-slot transmit scheduler in front of a lane serializer.
// Presents one registered byte every WIDTH cycles, sends SYNC_BYTES alignment
// symbols after start, then round-robin arbitrates NREQ requesters per slot.
// Optional feature macro: TX_SCHED_SKIP_EN (periodic SKIP_BYTE insertion in RUN).
//
// Handshake: req[i] is a level "byte available"; it is only looked at in the
// boundary cycle (last cycle of a slot). gnt[i] is a one-cycle pop pulse in that
// same cycle, and data_in for requester i is captured on the edge ending it.
module serial_tx_scheduler #(
    parameter int               WIDTH         = 8,
    parameter int               NREQ          = 4,
    parameter int               SYNC_BYTES    = 4,
    parameter logic [WIDTH-1:0] IDLE_BYTE     = 8'hBC,
    parameter logic [WIDTH-1:0] SKIP_BYTE     = 8'h1C,
    parameter int               SKIP_INTERVAL = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      ser_data,
    output logic                  ser_enb,
    output logic                  ser_load,
    output logic                  busy
);

    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(SYNC_BYTES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   slot_cnt, slot_nxt;
    logic [PW-1:0]   rr_ptr, rr_nxt;
    logic [CW-1:0]   sync_cnt, sync_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic            enb_nxt, load_nxt, busy_nxt;
    logic            boundary, found, do_arb;
    logic [PW-1:0]   pick, cand;

`ifdef TX_SCHED_SKIP_EN
    localparam int KW = $clog2(SKIP_INTERVAL + 1);
    logic [KW-1:0]   skip_cnt, skip_nxt;
`else
    // Skip parameters have no function in this build.
    logic unused_skip;
    assign unused_skip = (^SKIP_BYTE) ^ (SKIP_INTERVAL != 0);
`endif

    assign boundary = (slot_cnt == SW'(WIDTH - 1));

    // Round-robin search starting at rr_ptr; first requester with req high wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PW'((int'(rr_ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state, slot timing, byte selection and grant pulse.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot_cnt;
        rr_nxt    = rr_ptr;
        sync_nxt  = sync_cnt;
        data_nxt  = ser_data;
        enb_nxt   = ser_enb;
        load_nxt  = 1'b0;
        busy_nxt  = busy;
        gnt       = '0;
        do_arb    = 1'b0;
`ifdef TX_SCHED_SKIP_EN
        skip_nxt  = skip_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SYNC;
                    slot_nxt  = '0;
                    sync_nxt  = '0;
                    data_nxt  = IDLE_BYTE;
                    enb_nxt   = 1'b1;
                    load_nxt  = 1'b1;
                    busy_nxt  = 1'b1;
`ifdef TX_SCHED_SKIP_EN
                    skip_nxt  = '0;
`endif
                end
            end
            ST_SYNC, ST_RUN: begin
                if (!boundary) begin
                    slot_nxt = slot_cnt + 1'b1;
                end else begin
                    slot_nxt = '0;
                    if (!start) begin
                        // Stop only takes effect at a slot end, never mid-byte.
                        state_nxt = ST_IDLE;
                        sync_nxt  = '0;
                        enb_nxt   = 1'b0;
                        busy_nxt  = 1'b0;
                    end else begin
                        load_nxt = 1'b1;
                        if (state == ST_SYNC && sync_cnt != CW'(SYNC_BYTES - 1)) begin
                            sync_nxt = sync_cnt + 1'b1;
                            data_nxt = IDLE_BYTE;
                        end else begin
                            // Last sync slot ends here: the first RUN byte is chosen now.
                            if (state == ST_SYNC) begin
                                sync_nxt  = sync_cnt + 1'b1;
                                state_nxt = ST_RUN;
                            end
`ifdef TX_SCHED_SKIP_EN
                            if (skip_cnt == KW'(SKIP_INTERVAL)) begin
                                data_nxt = SKIP_BYTE;
                                skip_nxt = '0;
                            end else begin
                                skip_nxt = skip_cnt + 1'b1;
                                do_arb   = 1'b1;
                            end
`else
                            do_arb = 1'b1;
`endif
                        end
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (do_arb) begin
            if (found) begin
                gnt[pick] = 1'b1;
                data_nxt  = data_in[pick*WIDTH +: WIDTH];
                rr_nxt    = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
            end else begin
                data_nxt  = IDLE_BYTE;
            end
        end

        // A reset cycle never pops a requester.
        if (reset) begin
            gnt = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            slot_cnt <= '0;
            rr_ptr   <= '0;
            sync_cnt <= '0;
            ser_data <= '0;
            ser_enb  <= 1'b0;
            ser_load <= 1'b0;
            busy     <= 1'b0;
`ifdef TX_SCHED_SKIP_EN
            skip_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            slot_cnt <= slot_nxt;
            rr_ptr   <= rr_nxt;
            sync_cnt <= sync_nxt;
            ser_data <= data_nxt;
            ser_enb  <= enb_nxt;
            ser_load <= load_nxt;
            busy     <= busy_nxt;
`ifdef TX_SCHED_SKIP_EN
            skip_cnt <= skip_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Testbench for serial_tx_scheduler: slot-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_serial_tx_scheduler;

    localparam int         W     = 8;
    localparam int         N     = 4;
    localparam int         SB    = 4;
    localparam logic [7:0] IDLEB = 8'hBC;
    localparam logic [7:0] SKIPB = 8'h1C;
    localparam int         SKI   = 16;

    // Clock and reset block
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data_in = '0;
    logic [N-1:0]   gnt;
    logic [W-1:0]   ser_data;
    logic           ser_enb, ser_load, busy;

    always #5 clk = ~clk;

    serial_tx_scheduler #(
        .WIDTH(W), .NREQ(N), .SYNC_BYTES(SB),
        .IDLE_BYTE(IDLEB), .SKIP_BYTE(SKIPB), .SKIP_INTERVAL(SKI)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .req(req), .data_in(data_in),
        .gnt(gnt), .ser_data(ser_data), .ser_enb(ser_enb), .ser_load(ser_load),
        .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the link is either off or inside a slot; slots are
    // numbered from start, the first SB are alignment symbols.
    bit         m_on = 0;
    int         m_slot = 0;
    int         m_nbytes = 0;
    int         m_rr = 0;
    int         m_skipc = 0;
    logic [W-1:0] m_data = '0;
    bit         m_enb = 0, m_load = 0, m_busy = 0;

    // Observation queues for the directed scenarios
    logic [N-1:0] obs_gnt[$];
    logic [W-1:0] obs_data[$];
    bit           prev_gnt = 0;

    // Scoreboard: compare every cycle, then advance the model by one cycle.
    always @(negedge clk) begin
        int k;
        bit bnd, choose, skip_now;
        logic [N-1:0] e_gnt;
        k = -1;
        for (int i = 0; i < N; i++)
            if (k < 0 && req[(m_rr + i) % N]) k = (m_rr + i) % N;
        bnd = m_on && (m_slot == W - 1);
        choose = bnd && start && (m_nbytes >= SB - 1);
        skip_now = 0;
`ifdef TX_SCHED_SKIP_EN
        skip_now = choose && (m_skipc == SKI);
`endif
        e_gnt = (!reset && choose && !skip_now && k >= 0) ? (4'b0001 << k) : 4'b0000;

        check("gnt", 32'(gnt), 32'(e_gnt));
        check("ser_data", 32'(ser_data), 32'(m_data));
        check("ser_enb", 32'(ser_enb), 32'(m_enb));
        check("ser_load", 32'(ser_load), 32'(m_load));
        check("busy", 32'(busy), 32'(m_busy));

        if (gnt != 0) obs_gnt.push_back(gnt);
        if (ser_load && prev_gnt) obs_data.push_back(ser_data);
        prev_gnt = (gnt != 0);

        if (reset) begin
            m_on = 0; m_slot = 0; m_nbytes = 0; m_rr = 0; m_skipc = 0;
            m_data = '0; m_enb = 0; m_load = 0; m_busy = 0;
        end else if (!m_on) begin
            m_load = 0;
            if (start) begin
                m_on = 1; m_slot = 0; m_nbytes = 0; m_skipc = 0;
                m_data = IDLEB; m_enb = 1; m_load = 1; m_busy = 1;
            end
        end else if (bnd) begin
            m_slot = 0;
            if (!start) begin
                m_on = 0; m_enb = 0; m_busy = 0; m_load = 0;
            end else begin
                m_load = 1;
                m_nbytes++;
                if (!choose) m_data = IDLEB;
                else if (skip_now) begin
                    m_data = SKIPB;
                    m_skipc = 0;
                end else begin
                    m_skipc++;
                    if (k >= 0) begin
                        m_data = data_in[k*W +: W];
                        m_rr = (k + 1) % N;
                    end else m_data = IDLEB;
                end
            end
        end else begin
            m_slot++;
            m_load = 0;
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    // Raise start and count sample points until ser_enb (and optionally gnt) appear.
    task automatic start_and_measure(input bit want_gnt, output int n_enb, output int n_gnt);
        bit done;
        start = 1'b1;
        n_enb = 0;
        n_gnt = 0;
        done = 0;
        for (int n = 1; n <= 100 && !done; n++) begin
            @(negedge clk);
            if (ser_enb && n_enb == 0) n_enb = n;
            if (gnt != 0 && n_gnt == 0) n_gnt = n;
            done = want_gnt ? (n_gnt != 0) : (n_enb != 0);
        end
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] exp_q[$];
    logic [W-1:0] exp_d[$];
    int n_enb, n_gnt, n_off;

    initial begin
        // Phase A: start with no requesters
        do_reset();
        start_and_measure(0, n_enb, n_gnt);
        check("enb_latency", n_enb, 2);
        obs_gnt.delete();
        tick(40);
        check("idle_no_gnt", obs_gnt.size(), 0);
        check("idle_byte", 32'(ser_data), 32'h000000BC);

        // Phase B: all requesters busy, rotation 0,1,2,3,0
        data_in = {8'h43, 8'h32, 8'h21, 8'h10};
        req = 4'b1111;
        obs_gnt.delete();
        obs_data.delete();
        tick(40);
        req = 4'b0000;
        tick(1);
        exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_d = {8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
        check("rr_len", obs_gnt.size(), 5);
        check("rr_data_len", obs_data.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < obs_gnt.size()) check("rr_gnt", 32'(obs_gnt[i]), 32'(exp_q[i]));
            if (i < obs_data.size()) check("rr_data", 32'(obs_data[i]), 32'(exp_d[i]));
        end

        // Phase C: pointer wrap 2,3,2,3
        obs_gnt.delete();
        req = 4'b0100;
        for (int i = 0; i < 20 && obs_gnt.size() < 1; i++) tick(1);
        req = 4'b1100;
        for (int i = 0; i < 40 && obs_gnt.size() < 4; i++) tick(1);
        req = 4'b0000;
        exp_q = {4'b0100, 4'b1000, 4'b0100, 4'b1000};
        check("wrap_len", obs_gnt.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < obs_gnt.size()) check("wrap_gnt", 32'(obs_gnt[i]), 32'(exp_q[i]));

        // Phase D: drop start three cycles into a data byte
        obs_gnt.delete();
        req = 4'b0001;
        for (int i = 0; i < 20 && obs_gnt.size() < 1; i++) tick(1);
        check("stop_pre_gnt", obs_gnt.size(), 1);
        tick(2);
        start = 1'b0;
        req = 4'b1111;
        obs_gnt.delete();
        n_off = 0;
        for (int n = 1; n <= 20 && n_off == 0; n++) begin
            @(negedge clk);
            if (!ser_enb) n_off = n;
        end
        tick(10);
        check("stop_enb_off", n_off, 7);
        check("stop_no_gnt", obs_gnt.size(), 0);
        check("stop_busy", 32'(busy), 0);
        check("stop_hold", 32'(ser_data), 32'h00000010);

        // Phase E: fresh start, first grant after SB alignment bytes
        do_reset();
        start_and_measure(1, n_enb, n_gnt);
        check("run_enb_latency", n_enb, 2);
        check("first_gnt_latency", n_gnt, 33);

        // Phase F: reset mid-byte in RUN, then restart
        req = 4'b0001;
        tick(20);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        start = 1'b0;
        check("rst_data", 32'(ser_data), 0);
        check("rst_enb", 32'(ser_enb), 0);
        check("rst_load", 32'(ser_load), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt", 32'(gnt), 0);
        tick(1);
        start_and_measure(1, n_enb, n_gnt);
        check("restart_enb", n_enb, 2);
        check("restart_gnt", n_gnt, 33);

        // Phase G: random traffic, start toggles and rare resets
        for (int c = 0; c < 3000; c++) begin
            req = N'($urandom_range(0, 15));
            data_in = {$urandom};
            if ($urandom_range(0, 99) == 0) start = ~start;
            reset = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
